// File: rtl/uart_receiver.sv
// 8N1 UART receiver: oversampled rx, start-bit confirmation at mid-bit, stop-bit validation.
// Define UART_RX_PARITY_EN to receive 8E1 frames with a parity-error strobe.
module uart_receiver #(
   parameter int OVERSAMPLE = 16,
   parameter int SAMPLE_PT  = OVERSAMPLE / 2 - 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       rx,
   output logic [7:0] data_out,
   output logic       valid,
   output logic       frame_err,
   output logic       parity_err,
   output logic       busy
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [TW-1:0] TICK_MID  = TW'(SAMPLE_PT);
   localparam logic [TW-1:0] TICK_ONE  = TW'(1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
`ifdef UART_RX_PARITY_EN
      , PARITY  = 3'd5
`endif
   } state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   tick_q, tick_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic [7:0]      shift_q, shift_d;
   logic [7:0]      data_q, data_d;
   logic            valid_q, valid_d;
   logic            frame_err_q, frame_err_d;
   logic            rx_meta_q, rx_meta_d;
   logic            rx_s_q, rx_s_d;
`ifdef UART_RX_PARITY_EN
   logic            parity_bit_q, parity_bit_d;
   logic            parity_err_q, parity_err_d;
`endif

   always_comb begin
      state_d     = state_q;
      tick_d      = tick_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      data_d      = data_q;
      valid_d     = 1'b0;
      frame_err_d = 1'b0;
      rx_meta_d   = rx;
      rx_s_d      = rx_meta_q;
`ifdef UART_RX_PARITY_EN
      parity_bit_d = parity_bit_q;
      parity_err_d = 1'b0;
`endif

      case (state_q)
         IDLE: begin
            tick_d    = '0;
            bit_idx_d = '0;
            if (!rx_s_q) state_d = START;
         end

         // A start bit must still be low at its midpoint; this also realigns
         // the tick counter so every later sample lands mid-bit.
         START: if (en) begin
            if (tick_q == TICK_MID) begin
               tick_d    = '0;
               bit_idx_d = '0;
               state_d   = rx_s_q ? IDLE : DATA;
            end else begin
               tick_d = tick_q + TICK_ONE;
            end
         end

         DATA: if (en) begin
            if (tick_q == TICK_LAST) begin
               tick_d  = '0;
               shift_d = {rx_s_q, shift_q[7:1]};
               if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               tick_d = tick_q + TICK_ONE;
            end
         end

`ifdef UART_RX_PARITY_EN
         PARITY: if (en) begin
            if (tick_q == TICK_LAST) begin
               tick_d       = '0;
               parity_bit_d = rx_s_q;
               state_d      = STOP;
            end else begin
               tick_d = tick_q + TICK_ONE;
            end
         end
`endif

         // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge.
         STOP: if (en) begin
            if (tick_q == TICK_LAST) begin
               tick_d = '0;
               data_d = shift_q;
               if (rx_s_q) begin
                  valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                  parity_err_d = (parity_bit_q != ^shift_q);
`endif
                  state_d = IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = WAIT_HIGH;
               end
            end else begin
               tick_d = tick_q + TICK_ONE;
            end
         end

         WAIT_HIGH: if (rx_s_q) state_d = IDLE;

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         tick_q      <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         rx_meta_q   <= 1'b1;
         rx_s_q      <= 1'b1;
`ifdef UART_RX_PARITY_EN
         parity_bit_q <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         tick_q      <= tick_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
         rx_meta_q   <= rx_meta_d;
         rx_s_q      <= rx_s_d;
`ifdef UART_RX_PARITY_EN
         parity_bit_q <= parity_bit_d;
         parity_err_q <= parity_err_d;
`endif
      end
   end

   assign data_out  = data_q;
   assign valid     = valid_q;
   assign frame_err = frame_err_q;
   assign busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Directed self-checking bench for uart_receiver (OVERSAMPLE=16, en every 4 clk, 64 clk per bit).
module tb_uart_receiver;

   localparam int BIT_CLK = 64;

   logic       clk;
   logic       reset;
   logic       en;
   logic       rx;
   logic [7:0] data_out;
   logic       valid;
   logic       frame_err;
   logic       parity_err;
   logic       busy;

   int checks;
   int errors;

   int         valid_cycles;
   int         valid_rises;
   int         ferr_cycles;
   int         perr_cycles;
   int         vp_cycles;
   int         bad_combo;
   logic       valid_prev;
   logic       busy_at_valid;
   logic [7:0] cap [0:15];

   uart_receiver #(.OVERSAMPLE(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .rx         (rx),
      .data_out   (data_out),
      .valid      (valid),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .busy       (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      en = 1'b0;
      forever begin
         repeat (3) @(negedge clk);
         en = 1'b1;
         @(negedge clk);
         en = 1'b0;
      end
   end

   // Strobe monitor, sampled on the inactive edge
   initial begin
      valid_cycles = 0; valid_rises = 0; ferr_cycles = 0; perr_cycles = 0;
      vp_cycles = 0; bad_combo = 0; valid_prev = 1'b0; busy_at_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (valid === 1'b1) begin
            cap[valid_cycles[3:0]] = data_out;
            valid_cycles++;
            busy_at_valid = busy;
            if (valid_prev !== 1'b1) valid_rises++;
         end
         if (frame_err === 1'b1) ferr_cycles++;
         if (parity_err === 1'b1) perr_cycles++;
         if (valid === 1'b1 && parity_err === 1'b1) vp_cycles++;
         if (frame_err === 1'b1 && (valid === 1'b1 || parity_err === 1'b1)) bad_combo++;
         valid_prev = valid;
      end
   end

   task automatic send_bit(input logic b);
      rx = b;
      repeat (BIT_CLK) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input logic bad_par);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      send_bit((^d) ^ bad_par);
`else
      if (bad_par) rx = 1'b1;
`endif
      send_bit(stop);
   endtask

   task automatic test_reset;
      reset = 1'b0;
      rx    = 1'b1;
      repeat (5) @(negedge clk);
      checks++;
      if (data_out !== 8'h00) begin errors++; $display("[TB] FAIL reset_data got=%h exp=00", data_out); end
      checks++;
      if ({valid, frame_err, parity_err} !== 3'b000) begin errors++; $display("[TB] FAIL reset_strobes got=%b exp=000", {valid, frame_err, parity_err}); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
      reset = 1'b1;
      repeat (20) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy got=%b exp=0", busy); end
   endtask

   task automatic test_good_frame;
      int v0, r0, f0;
      v0 = valid_cycles; r0 = valid_rises; f0 = ferr_cycles;
      send_frame(8'hA5, 1'b1, 1'b0);
      repeat (20) @(negedge clk);
      checks++;
      if (valid_cycles - v0 !== 1) begin errors++; $display("[TB] FAIL good_valid_cycles got=%0d exp=1", valid_cycles - v0); end
      checks++;
      if (valid_rises - r0 !== 1) begin errors++; $display("[TB] FAIL good_valid_pulses got=%0d exp=1", valid_rises - r0); end
      checks++;
      if (cap[v0[3:0]] !== 8'hA5) begin errors++; $display("[TB] FAIL good_strobe_data got=%h exp=a5", cap[v0[3:0]]); end
      checks++;
      if (data_out !== 8'hA5) begin errors++; $display("[TB] FAIL good_data_hold got=%h exp=a5", data_out); end
      checks++;
      if (ferr_cycles - f0 !== 0) begin errors++; $display("[TB] FAIL good_frame_err got=%0d exp=0", ferr_cycles - f0); end
      checks++;
      if (busy_at_valid !== 1'b0) begin errors++; $display("[TB] FAIL good_busy_with_valid got=%b exp=0", busy_at_valid); end
   endtask

   task automatic test_frame_error;
      int v0, f0;
      v0 = valid_cycles; f0 = ferr_cycles;
      send_frame(8'h3C, 1'b0, 1'b0);
      repeat (3 * BIT_CLK) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("[TB] FAIL ferr_busy_held got=%b exp=1", busy); end
      rx = 1'b1;
      repeat (10) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ferr_busy_release got=%b exp=0", busy); end
      checks++;
      if (ferr_cycles - f0 !== 1) begin errors++; $display("[TB] FAIL ferr_pulses got=%0d exp=1", ferr_cycles - f0); end
      checks++;
      if (data_out !== 8'h3C) begin errors++; $display("[TB] FAIL ferr_data got=%h exp=3c", data_out); end
      repeat (12 * BIT_CLK) @(negedge clk);
      checks++;
      if (valid_cycles - v0 !== 0) begin errors++; $display("[TB] FAIL ferr_no_valid got=%0d exp=0", valid_cycles - v0); end
      checks++;
      if (ferr_cycles - f0 !== 1) begin errors++; $display("[TB] FAIL ferr_no_repeat got=%0d exp=1", ferr_cycles - f0); end
   endtask

   task automatic test_glitch;
      int v0, f0;
      v0 = valid_cycles; f0 = ferr_cycles;
      rx = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("[TB] FAIL glitch_busy_start got=%b exp=1", busy); end
      repeat (10) @(negedge clk);
      rx = 1'b1;
      repeat (80) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL glitch_busy_end got=%b exp=0", busy); end
      checks++;
      if ((valid_cycles - v0) + (ferr_cycles - f0) !== 0) begin errors++; $display("[TB] FAIL glitch_strobes got=%0d exp=0", (valid_cycles - v0) + (ferr_cycles - f0)); end
   endtask

   task automatic test_reset_midframe;
      int v0, f0;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      rx = 1'b1;
      repeat (32) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("[TB] FAIL abort_busy_before got=%b exp=1", busy); end
      v0 = valid_cycles; f0 = ferr_cycles;
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      checks++;
      if ({data_out, valid, frame_err, parity_err, busy} !== 12'h000) begin
         errors++; $display("[TB] FAIL abort_reset_outputs got=%h/%b%b%b%b exp=00/0000", data_out, valid, frame_err, parity_err, busy);
      end
      repeat (6 * BIT_CLK) @(negedge clk);
      checks++;
      if ((valid_cycles - v0) + (ferr_cycles - f0) !== 0) begin errors++; $display("[TB] FAIL abort_no_strobe got=%0d exp=0", (valid_cycles - v0) + (ferr_cycles - f0)); end
      send_frame(8'h81, 1'b1, 1'b0);
      repeat (20) @(negedge clk);
      checks++;
      if (valid_cycles - v0 !== 1) begin errors++; $display("[TB] FAIL abort_next_valid got=%0d exp=1", valid_cycles - v0); end
      checks++;
      if (data_out !== 8'h81) begin errors++; $display("[TB] FAIL abort_next_data got=%h exp=81", data_out); end
   endtask

   task automatic test_back_to_back;
      int v0, f0;
      v0 = valid_cycles; f0 = ferr_cycles;
      send_frame(8'h55, 1'b1, 1'b0);
      send_frame(8'h00, 1'b1, 1'b0);
      repeat (20) @(negedge clk);
      checks++;
      if (valid_cycles - v0 !== 2) begin errors++; $display("[TB] FAIL b2b_valid_count got=%0d exp=2", valid_cycles - v0); end
      checks++;
      if (cap[v0[3:0]] !== 8'h55) begin errors++; $display("[TB] FAIL b2b_first_data got=%h exp=55", cap[v0[3:0]]); end
      checks++;
      if (cap[(v0 + 1) % 16] !== 8'h00) begin errors++; $display("[TB] FAIL b2b_second_data got=%h exp=00", cap[(v0 + 1) % 16]); end
      checks++;
      if (ferr_cycles - f0 !== 0) begin errors++; $display("[TB] FAIL b2b_frame_err got=%0d exp=0", ferr_cycles - f0); end
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity;
      int v0, p0, vp0;
      v0 = valid_cycles; p0 = perr_cycles; vp0 = vp_cycles;
      send_frame(8'h07, 1'b1, 1'b1);
      repeat (20) @(negedge clk);
      checks++;
      if (valid_cycles - v0 !== 1) begin errors++; $display("[TB] FAIL par_bad_valid got=%0d exp=1", valid_cycles - v0); end
      checks++;
      if (vp_cycles - vp0 !== 1) begin errors++; $display("[TB] FAIL par_bad_same_cycle got=%0d exp=1", vp_cycles - vp0); end
      checks++;
      if (data_out !== 8'h07) begin errors++; $display("[TB] FAIL par_bad_data got=%h exp=07", data_out); end
      p0 = perr_cycles;
      send_frame(8'h07, 1'b1, 1'b0);
      repeat (20) @(negedge clk);
      checks++;
      if (valid_cycles - v0 !== 2) begin errors++; $display("[TB] FAIL par_good_valid got=%0d exp=2", valid_cycles - v0); end
      checks++;
      if (perr_cycles - p0 !== 0) begin errors++; $display("[TB] FAIL par_good_no_err got=%0d exp=0", perr_cycles - p0); end
   endtask
`else
   task automatic test_parity;
      checks++;
      if (perr_cycles !== 0) begin errors++; $display("[TB] FAIL parity_tied_low got=%0d exp=0", perr_cycles); end
   endtask
`endif

   task automatic test_exclusive_strobes;
      checks++;
      if (bad_combo !== 0) begin errors++; $display("[TB] FAIL strobe_overlap got=%0d exp=0", bad_combo); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_good_frame();
      test_frame_error();
      test_glitch();
      test_reset_midframe();
      test_back_to_back();
      test_parity();
      test_exclusive_strobes();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
